startup_sequencer: RTL
======================

STARTUP_SEQUENCER -- requirements
Module: startup_sequencer

Interface
REQ-001 SHALL have parameter BOOT_TICKS, default 10; bootstrap-charge duration in i_tick pulses (us).
REQ-002 SHALL have parameter PRECH_TICKS, default 4; tank precharge duration (forced sigma=1) in i_tick pulses.
REQ-003 SHALL have parameter OC_LIMIT_MA, default 12000; overcurrent threshold on i_Ibat_mA.
REQ-004 SHALL have parameter OC_FILTER, default 3; consecutive over-limit ticks required to trip.
REQ-005 SHALL have port i_clock, input, 1; the only clock, 100 MHz.
REQ-006 SHALL have port i_RST, input, 1; reset, asynchronous and active-high.
REQ-007 SHALL have port i_enable, input, 1; debounced converter enable.
REQ-008 SHALL have port i_tick, input, 1; single-cycle 1 MHz strobe, synchronous to i_clock.
REQ-009 SHALL have port i_MOSFET, input, 4; hybrid-controller gate pattern {Q4,Q3,Q2,Q1}, after dead time.
REQ-010 SHALL have port i_Ibat_mA, input, 32; battery current in mA, unsigned.
REQ-011 SHALL have port o_Q, output, 4; registered gate drive to the H-bridge.
REQ-012 SHALL have port o_ON, output, 1; high in PRECHARGE and RUN.
REQ-013 SHALL have port o_VG, output, 1; high only in RUN.
REQ-014 SHALL have port o_ctrl_rst, output, 1; active-high hold-reset for the hybrid controller and PI; high in every state except RUN.
REQ-015 SHALL have port o_fault, output, 2; fault code: bit0 = shoot-through, bit1 = overcurrent.
REQ-016 SHALL have port o_state, output, 3; current state encoding, for debug display.

Function
REQ-017 SHALL implement the states IDLE=0, BOOT=1, PRECHARGE=2, RUN=3 and FAULT=4.
REQ-018 SHALL drive o_Q, one cycle after the state/input change, to: IDLE 0000; BOOT 1100 (low sides); PRECHARGE 1001; RUN i_MOSFET; FAULT 0000.
REQ-019 SHALL go IDLE->BOOT on the first cycle with i_enable=1, clearing the 8-bit tick counter.
REQ-020 SHALL increment the tick counter once per i_tick pulse in BOOT and PRECHARGE, saturating at 255.
REQ-021 SHALL go BOOT->PRECHARGE on the cycle after the counter reaches BOOT_TICKS, clearing the counter.
REQ-022 SHALL go PRECHARGE->RUN on the cycle after the counter reaches PRECH_TICKS.
REQ-023 SHALL detect shoot-through in RUN as (i_MOSFET[0]&i_MOSFET[2])|(i_MOSFET[1]&i_MOSFET[3]).
REQ-024 SHALL, on shoot-through, drive o_Q=0000 on the next edge (never forward the illegal pattern), enter FAULT and set o_fault[0].
REQ-025 SHALL count i_tick pulses with i_Ibat_mA > OC_LIMIT_MA, clearing the count on any tick with i_Ibat_mA <= OC_LIMIT_MA.
REQ-026 SHALL, when the count reaches OC_FILTER in BOOT, PRECHARGE or RUN, enter FAULT and set o_fault[1].
REQ-027 SHALL set both o_fault bits (11) when shoot-through and overcurrent trip in the same cycle.
REQ-028 SHALL keep o_fault sticky in FAULT; FAULT SHALL exit only to IDLE, when i_enable=0; o_fault SHALL clear on that exit.
REQ-029 SHALL go to IDLE on the next cycle when i_enable=0 in BOOT, PRECHARGE or RUN; an enable drop takes priority over a fault trip in the same cycle.
REQ-030 SHALL not restart from FAULT while i_enable is held high.

Reset
REQ-031 SHALL, on i_RST=1, asynchronously set: state=IDLE, counters=0, o_Q=0000, o_ON=0, o_VG=0, o_ctrl_rst=1, o_fault=00, o_state=0.
REQ-032 SHALL, on reset asserted mid-RUN, clear o_Q within the same reset assertion, without waiting for a clock edge.
REQ-033 SHALL, after reset release, stay in IDLE until i_enable is sampled high.

Structure
REQ-034 SHALL place the state encoding, fault-code constants and the BOOT/PRECHARGE/OFF gate patterns in a shared package, hb_seq_pkg.
REQ-035 SHALL implement the overcurrent consecutive-tick comparator as one sub-module, oc_filter.

Verification
REQ-036 Nominal start: i_enable=1 with a tick every 100 cycles -> o_Q=1100 for 10 ticks, then 1001 for 4 ticks; o_ON rises at tick 10, o_VG rises at tick 14; then o_Q follows i_MOSFET with 1-cycle latency.
REQ-037 Shoot-through: in RUN, i_MOSFET=0101 for one cycle -> o_Q=0000 on the next edge, o_state=4, o_fault=01; i_enable=0 -> IDLE, o_fault=00.
REQ-038 Overcurrent filter: i_Ibat_mA=12001 for 2 ticks, then 11000 for 1 tick, then 12001 for 3 ticks -> trip only on the 3rd tick of the second burst; o_fault=10.
REQ-039 Simultaneous events: shoot-through and 3rd overcurrent tick in the same cycle -> o_fault=11; enable drop in the same cycle as a trip -> IDLE, o_fault=00.
REQ-040 Reset: i_RST pulsed mid-RUN -> o_Q=0000 asynchronously; after release, start with i_enable=1 -> full BOOT sequence again.

Source files
------------

// File: rtl/hb_seq_pkg.sv
// Shared definitions for the H-bridge startup sequencer: state encoding,
// fault codes, fixed gate patterns and small decode helpers.
package hb_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BOOT      = 3'd1,
    ST_PRECHARGE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_SHOOT = 2'b01;
  localparam logic [1:0] FAULT_OC    = 2'b10;

  // Gate patterns are {Q4,Q3,Q2,Q1}.
  localparam logic [3:0] GATE_OFF   = 4'b0000;
  localparam logic [3:0] GATE_BOOT  = 4'b1100;
  localparam logic [3:0] GATE_PRECH = 4'b1001;

  localparam int TICK_CNT_W = 8;
  localparam int OC_CNT_W   = 8;

  // A leg is shorted when both of its switches (Q1/Q3 or Q2/Q4) conduct.
  function automatic logic is_shoot(input logic [3:0] gates);
    return (gates[0] & gates[2]) | (gates[1] & gates[3]);
  endfunction

  function automatic logic is_active(input state_t s);
    return (s == ST_BOOT) || (s == ST_PRECHARGE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/oc_filter.sv
// Consecutive-tick overcurrent filter: trips on the tick that brings the run
// of over-limit samples up to FILTER.
module oc_filter
  import hb_seq_pkg::*;
#(
  parameter int unsigned LIMIT_MA = 12000,
  parameter int unsigned FILTER   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        tick,
  input  logic [31:0] ibat_ma,
  output logic        trip
);

  logic                over;
  logic [OC_CNT_W-1:0] count;
  logic [OC_CNT_W:0]   count_inc;

  assign over      = ibat_ma > LIMIT_MA;
  assign count_inc = {1'b0, count} + {{OC_CNT_W{1'b0}}, 1'b1};
  // Combinational so the trip lands in the same cycle as the offending tick.
  assign trip      = !clr && tick && over && (32'(count_inc) >= FILTER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      if (!over) begin
        count <= '0;
      end else if (count != {OC_CNT_W{1'b1}}) begin
        count <= count + OC_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/startup_sequencer.sv
// H-bridge startup sequencer: bootstrap charge, tank precharge, then forwards
// the hybrid controller's gate pattern while guarding against shoot-through and overcurrent.
module startup_sequencer
  import hb_seq_pkg::*;
#(
  parameter int unsigned BOOT_TICKS  = 10,
  parameter int unsigned PRECH_TICKS = 4,
  parameter int unsigned OC_LIMIT_MA = 12000,
  parameter int unsigned OC_FILTER   = 3
) (
  input  logic        i_clock,
  input  logic        i_RST,
  input  logic        i_enable,
  input  logic        i_tick,
  input  logic [3:0]  i_MOSFET,
  input  logic [31:0] i_Ibat_mA,
  output logic [3:0]  o_Q,
  output logic        o_ON,
  output logic        o_VG,
  output logic        o_ctrl_rst,
  output logic [1:0]  o_fault,
  output logic [2:0]  o_state
);

  localparam logic [TICK_CNT_W-1:0] BOOT_LIM  = TICK_CNT_W'(BOOT_TICKS);
  localparam logic [TICK_CNT_W-1:0] PRECH_LIM = TICK_CNT_W'(PRECH_TICKS);
  localparam logic [TICK_CNT_W-1:0] TICK_MAX  = {TICK_CNT_W{1'b1}};

  state_t                state;
  logic [TICK_CNT_W-1:0] tick_cnt;
  logic                  shoot;
  logic                  oc_trip;
  logic                  oc_clr;

  assign shoot   = is_shoot(i_MOSFET);
  assign oc_clr  = !is_active(state);
  assign o_state = state;

  oc_filter #(
    .LIMIT_MA (OC_LIMIT_MA),
    .FILTER   (OC_FILTER)
  ) u_oc_filter (
    .clk     (i_clock),
    .rst     (i_RST),
    .clr     (oc_clr),
    .tick    (i_tick),
    .ibat_ma (i_Ibat_mA),
    .trip    (oc_trip)
  );

  always_ff @(posedge i_clock or posedge i_RST) begin
    if (i_RST) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      o_Q        <= GATE_OFF;
      o_ON       <= 1'b0;
      o_VG       <= 1'b0;
      o_ctrl_rst <= 1'b1;
      o_fault    <= FAULT_NONE;
    end else begin
      // Drive outputs follow the state one cycle later; an illegal pattern is never forwarded.
      case (state)
        ST_BOOT:      o_Q <= GATE_BOOT;
        ST_PRECHARGE: o_Q <= GATE_PRECH;
        ST_RUN:       o_Q <= shoot ? GATE_OFF : i_MOSFET;
        default:      o_Q <= GATE_OFF;
      endcase
      o_ON       <= (state == ST_PRECHARGE) || (state == ST_RUN);
      o_VG       <= (state == ST_RUN);
      o_ctrl_rst <= (state != ST_RUN);

      case (state)
        ST_IDLE: begin
          if (i_enable) begin
            state    <= ST_BOOT;
            tick_cnt <= '0;
          end
        end
        ST_BOOT: begin
          if (!i_enable) begin
            state <= ST_IDLE;
          end else if (oc_trip) begin
            state   <= ST_FAULT;
            o_fault <= FAULT_OC;
          end else if (tick_cnt == BOOT_LIM) begin
            state    <= ST_PRECHARGE;
            tick_cnt <= '0;
          end else if (i_tick && (tick_cnt != TICK_MAX)) begin
            tick_cnt <= tick_cnt + TICK_CNT_W'(1);
          end
        end
        ST_PRECHARGE: begin
          if (!i_enable) begin
            state <= ST_IDLE;
          end else if (oc_trip) begin
            state   <= ST_FAULT;
            o_fault <= FAULT_OC;
          end else if (tick_cnt == PRECH_LIM) begin
            state    <= ST_RUN;
            tick_cnt <= '0;
          end else if (i_tick && (tick_cnt != TICK_MAX)) begin
            tick_cnt <= tick_cnt + TICK_CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            state <= ST_IDLE;
          end else if (shoot || oc_trip) begin
            state   <= ST_FAULT;
            o_fault <= (oc_trip ? FAULT_OC : FAULT_NONE) |
                       (shoot ? FAULT_SHOOT : FAULT_NONE);
          end
        end
        ST_FAULT: begin
          if (!i_enable) begin
            state   <= ST_IDLE;
            o_fault <= FAULT_NONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
          o_fault  <= FAULT_NONE;
        end
      endcase
    end
  end

endmodule
